cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//   Phase sequencer for the 8-bit RISC CPU. Runs an 8-phase fetch/execute cycle
//   and decodes phase, opcode and the ALU is_zero flag into datapath strobes.
//   Driven strobes: address mux select, memory read/write, IR/PC/ACC loads, data-bus enable.
//   Sits beside the alu: its opcode input comes from the IR; the same opcode drives alu.opcode.
// PARAMETERS
//   HALT_STICKY  1  1: HLT freezes the CPU until rst. 0: halt pulses for one cycle and HLT acts as NOP.
// PORTS
//   clk     in   1  sole clock; all state updates on its rising edge
//   rst     in   1  asynchronous, active-high reset
//   en      in   1  phase-advance enable; when low, state holds
//   opcode  in   3  IR opcode, per defines.v: HLT0 SKZ1 ADD2 AND3 XOR4 LDA5 STO6 JMP7
//   zero    in   1  alu is_zero (accumulator == 0)
//   sel     out  1  address mux: 1 = PC, 0 = IR operand address
//   rd      out  1  memory read enable
//   ld_ir   out  1  instruction register load
//   inc_pc  out  1  program counter increment
//   ld_pc   out  1  program counter load (jump target)
//   ld_ac   out  1  accumulator load from alu.out
//   data_e  out  1  drive accumulator onto data bus
//   wr      out  1  memory write strobe
//   halt    out  1  HLT executing or CPU halted
//   halted  out  1  registered sticky-halt flag
//   phase   out  3  current phase, for debug
// BEHAVIOUR
//   - State: phase[2:0] register and halted flag. Outputs are combinational from phase, opcode, zero and halted.
//   - On rst (async, any time, including mid-instruction): phase=0 and halted=0 immediately.
//     Outputs then read sel=1 and all other strobes 0.
//   - Phase advances 0->1->...->7->0 (wraps) on each clk where en=1 and halted=0.
//   - ALUOP = opcode in {ADD, AND, XOR, LDA}.
//   - Phase table (unlisted strobes are 0):
//       0 INST_ADDR : sel
//       1 INST_FETCH: sel, rd
//       2 INST_LOAD : sel, rd, ld_ir
//       3 IDLE      : sel, rd, ld_ir
//       4 OP_ADDR   : inc_pc; halt = (opcode==HLT)
//       5 OP_FETCH  : rd = ALUOP
//       6 ALU_OP    : rd = ALUOP; inc_pc = SKZ&zero; ld_pc = JMP; data_e = STO
//       7 STORE     : rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; data_e = STO; wr = STO
//   - opcode is only used in phases 4-7 (IR valid after phase 2/3). zero is sampled combinationally in phase 6.
//   - wr is asserted only in phase 7. data_e covers phases 6-7, so bus data settles one cycle before the write.
//   - HLT with HALT_STICKY=1: on the phase-4 edge with en=1, set halted=1 and hold phase at 4.
//     While halted: halt=1, every other strobe 0 (including sel); en is ignored. Only rst clears it.
//   - HLT with HALT_STICKY=0: halt=1 during phase 4 only; sequencing continues as a NOP.
//   - en=0: phase and halted hold; strobes stay at the current phase's decode (they are not forced to 0).
//     An external stall must therefore not rely on strobes dropping during the stall.
//   - en=0 and rst together: rst wins.
// STRUCTURE
//   - Add phase constants PH_INST_ADDR..PH_STORE (0..7) to defines.v, next to the OPCODE_* macros.
//   - Single module, no sub-modules. One sequential always block for phase/halted.
//     One combinational always block for the strobe decode, with defaults of 0 set before the case.
// TESTING
//   1 Reset, en=1, opcode=ADD(2), 8 cycles:
//     phase steps 0..7 then 0; rd=1 in phases 1,2,3,5,6,7; ld_ir in 2,3; inc_pc in 4 only; ld_ac in 7 only.
//   2 opcode=SKZ(1): with zero=1, inc_pc=1 in phases 4 and 6; with zero=0, inc_pc=1 in phase 4 only.
//     rd=0 in phases 5-7 in both cases.
//   3 opcode=JMP(7): ld_pc=1 in phases 6 and 7; inc_pc in 4 only; rd=0 in 5-7; wr never asserted.
//   4 opcode=STO(6): data_e=1 in phases 6 and 7; wr=1 in phase 7 only; ld_ac=0 throughout.
//   5 opcode=HLT(0), HALT_STICKY=1: halt=1 in phase 4; next cycle halted=1 and phase=4.
//     Hold 100 cycles with en toggling: all strobes except halt stay 0.
//     Assert rst: phase=0, sel=1, halted=0 without waiting for a clock edge.
//   6 en=0 for 3 cycles in phase 5 (opcode=LDA): phase stays 5 and rd stays 1.
//     Then assert rst asynchronously mid-phase 6: phase=0, sel=1, rd=0 before the next clk edge.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared phase/opcode encodings for the 8-bit RISC CPU controller.
package cpu_controller_pkg;

    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned OPCODE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    // Opcodes that read an operand from memory and load the accumulator
    function automatic logic is_aluop(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer; decodes phase, opcode and zero into datapath strobes.
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                data_e,
    output logic                wr,
    output logic                halt,
    output logic                halted,
    output logic [PHASE_W-1:0]  phase
);

    phase_t  state_q, state_d;
    logic    halted_q, halted_d;
    opcode_t op;
    logic    aluop;

    assign op     = opcode_t'(opcode);
    assign aluop  = is_aluop(op);
    assign phase  = state_q;
    assign halted = halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Sticky HLT freezes the phase at OP_ADDR instead of advancing
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (en && !halted_q) begin
            if (HALT_STICKY && (state_q == PH_OP_ADDR) && (op == OP_HLT)) begin
                halted_d = 1'b1;
            end else begin
                state_d = phase_t'(PHASE_W'(state_q + 3'd1));
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (state_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop;
                end
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == OP_SKZ) && zero;
                    ld_pc  = (op == OP_JMP);
                    data_e = (op == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (op == OP_JMP);
                    data_e = (op == OP_STO);
                    wr     = (op == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller (HALT_STICKY=1).
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, halted;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    cpu_controller #(.HALT_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .halted(halted),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt}
    logic [8:0] strobes;
    assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

    function automatic logic [8:0] row(input logic [7:0] s, input logic [7:0] r,
                                       input logic [7:0] i, input logic [7:0] inc,
                                       input logic [7:0] lp, input logic [7:0] la,
                                       input logic [7:0] de, input logic [7:0] w,
                                       input logic [7:0] h, input int p);
        return {s[p], r[p], i[p], inc[p], lp[p], la[p], de[p], w[p], h[p]};
    endfunction

    // Reset asserted between clock edges, released before the next rising edge
    task automatic do_reset(input logic [2:0] op, input logic z);
        @(negedge clk);
        opcode = op;
        zero   = z;
        en     = 1'b1;
        rst    = 1'b1;
        #2;
        rst    = 1'b0;
    endtask

    // Walk phases 0..7 and back to 0 against per-strobe phase masks
    task automatic run_instr(input string name, input logic [7:0] rd_t, input logic [7:0] inc_t,
                             input logic [7:0] lp_t, input logic [7:0] la_t,
                             input logic [7:0] de_t, input logic [7:0] wr_t);
        logic [7:0] sel_t = 8'h0F;
        logic [7:0] ir_t  = 8'h0C;
        logic [7:0] h_t   = 8'h00;
        logic [8:0] exp_s;
        for (int p = 0; p < 9; p++) begin
            if (p > 0) @(negedge clk);
            exp_s = row(sel_t, rd_t, ir_t, inc_t, lp_t, la_t, de_t, wr_t, h_t, p % 8);
            tests++;
            if (phase !== 3'(p % 8) || strobes !== exp_s || halted !== 1'b0) begin
                fails++;
                $display("FAIL %s step%0d: phase=%0d strobes=%b halted=%b, required phase=%0d strobes=%b halted=0",
                         name, p, phase, strobes, halted, p % 8, exp_s);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (phase !== 3'd0 || strobes !== 9'b1_0000_0000 || halted !== 1'b0) begin
            fails++;
            $display("FAIL reset: phase=%0d strobes=%b halted=%b, required 0 100000000 0",
                     phase, strobes, halted);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        do_reset(3'd2, 1'b0);
        run_instr("add", 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00);
    endtask

    task automatic test_skz;
        do_reset(3'd1, 1'b1);
        run_instr("skz_z1", 8'h0E, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00);
        do_reset(3'd1, 1'b0);
        run_instr("skz_z0", 8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_jmp;
        do_reset(3'd7, 1'b0);
        run_instr("jmp", 8'h0E, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_sto;
        do_reset(3'd6, 1'b1);
        run_instr("sto", 8'h0E, 8'h10, 8'h00, 8'h00, 8'hC0, 8'h80);
    endtask

    task automatic test_halt;
        do_reset(3'd0, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (phase !== 3'd4 || strobes !== 9'b0_0010_0001 || halted !== 1'b0) begin
            fails++;
            $display("FAIL hlt_ph4: phase=%0d strobes=%b halted=%b, required 4 000100001 0",
                     phase, strobes, halted);
        end
        @(negedge clk);
        tests++;
        if (phase !== 3'd4 || strobes !== 9'b0_0000_0001 || halted !== 1'b1) begin
            fails++;
            $display("FAIL hlt_frozen: phase=%0d strobes=%b halted=%b, required 4 000000001 1",
                     phase, strobes, halted);
        end
        for (int c = 0; c < 100; c++) begin
            en = c[0];
            opcode = 3'(c);
            @(negedge clk);
            tests++;
            if (phase !== 3'd4 || strobes !== 9'b0_0000_0001 || halted !== 1'b1) begin
                fails++;
                $display("FAIL hlt_hold c%0d: phase=%0d strobes=%b halted=%b, required 4 000000001 1",
                         c, phase, strobes, halted);
            end
        end
        en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (phase !== 3'd0 || sel !== 1'b1 || halted !== 1'b0 || halt !== 1'b0) begin
            fails++;
            $display("FAIL hlt_rst: phase=%0d sel=%b halted=%b halt=%b, required 0 1 0 0",
                     phase, sel, halted, halt);
        end
        rst = 1'b0;
    endtask

    task automatic test_stall;
        do_reset(3'd5, 1'b0);
        repeat (5) @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (phase !== 3'd5 || rd !== 1'b1) begin
                fails++;
                $display("FAIL stall c%0d: phase=%0d rd=%b, required 5 1", c, phase, rd);
            end
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if (phase !== 3'd6 || rd !== 1'b1) begin
            fails++;
            $display("FAIL resume: phase=%0d rd=%b, required 6 1", phase, rd);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (phase !== 3'd0 || sel !== 1'b1 || rd !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: phase=%0d sel=%b rd=%b, required 0 1 0", phase, sel, rd);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_skz();
        test_jmp();
        test_sto();
        test_halt();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
